// File: rtl/car_game_pkg.sv
// ---------------------------------------------------------------------------
// car_game_pkg : shared state encodings and default constants for the car game
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package car_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_HIT       = 3'd3,
    ST_OVER      = 3'd4
  } state_t;

  localparam logic [19:0] DEF_SPEED_INIT = 20'h1FFFF;
  localparam logic [19:0] DEF_SPEED_STEP = 20'h02000;
  localparam logic [19:0] DEF_SPEED_MIN  = 20'h05000;

  localparam int                FCNT_W  = 8;
  localparam logic [FCNT_W-1:0] CD_BAND = 8'd60;

  // Digit shown during the countdown; the band is fixed at 60 frames
  function automatic logic [1:0] countdown_digit(input logic [FCNT_W-1:0] f);
    if (f < CD_BAND)
      return 2'd3;
    else if (f < (CD_BAND + CD_BAND))
      return 2'd2;
    else
      return 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_sequencer_if.sv
// ---------------------------------------------------------------------------
// game_sequencer_if : player/collision inputs and game-flow outputs bundle
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface game_sequencer_if;
  import car_game_pkg::*;

  logic        start;
  logic        frame_tick;
  logic        collision;
  logic        traffic_passed;
  state_t      state;
  logic        game_active;
  logic        game_over;
  logic [19:0] speed;
  logic [15:0] score;
  logic [1:0]  lives;
  logic [1:0]  countdown;
  logic        flash;

  modport master (
    output start, frame_tick, collision, traffic_passed,
    input  state, game_active, game_over, speed, score, lives, countdown, flash
  );

  modport slave (
    input  start, frame_tick, collision, traffic_passed,
    output state, game_active, game_over, speed, score, lives, countdown, flash
  );

endinterface

`default_nettype wire

// File: rtl/game_sequencer_frame_timer.sv
// ---------------------------------------------------------------------------
// frame_timer : frame-tick counter wrapping at LIMIT-1, with synchronous clear
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module frame_timer #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 180
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clear,
  input  wire logic             enable,
  input  wire logic             frame_tick,
  output logic [WIDTH-1:0]      count_next,
  output logic                  terminal
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count;

  assign terminal = (count == LAST);

  // Next value is exported so callers can register outputs decoded from it
  always_comb begin
    count_next = count;
    if (clear)
      count_next = '0;
    else if (enable && frame_tick)
      count_next = terminal ? '0 : count + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else
      count <= count_next;
  end

endmodule

`default_nettype wire

// File: rtl/game_sequencer.sv
// ---------------------------------------------------------------------------
// game_sequencer : car-game flow FSM with lives, score and traffic speed ramp
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module game_sequencer
  import car_game_pkg::*;
#(
  parameter int          COUNTDOWN_FRAMES = 180,
  parameter int          HIT_FRAMES       = 90,
  parameter int          LIVES_INIT       = 3,
  parameter logic [19:0] SPEED_INIT       = DEF_SPEED_INIT,
  parameter logic [19:0] SPEED_STEP       = DEF_SPEED_STEP,
  parameter logic [19:0] SPEED_MIN        = DEF_SPEED_MIN,
  parameter int          LEVEL_PTS        = 10
) (
  input  wire logic      clk,
  input  wire logic      rst,
  game_sequencer_if.slave bus
);

  localparam logic [1:0]  LIVES_LOAD = 2'(LIVES_INIT);
  localparam logic [15:0] LEVEL_DIV  = 16'(LEVEL_PTS);

  state_t            cur_state, next_state;
  logic              start_q, start_rise, load_game;
  logic [FCNT_W-1:0] cd_next, hit_next;
  logic              cd_terminal, hit_terminal;
  logic [15:0]       score, score_inc;
  logic [19:0]       speed, speed_dec;
  logic [20:0]       speed_diff;
  logic [1:0]        lives;
  logic              level_up;
  logic              game_active_d, game_over_d, flash_d;
  logic [1:0]        countdown_d;

  assign start_rise = bus.start & ~start_q;
  assign load_game  = start_rise && (cur_state == ST_IDLE || cur_state == ST_OVER);

  // Each timer idles at zero outside its own phase, so entry always starts at frame 0
  frame_timer #(.WIDTH(FCNT_W), .LIMIT(COUNTDOWN_FRAMES)) u_cd_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (cur_state != ST_COUNTDOWN),
    .enable     (1'b1),
    .frame_tick (bus.frame_tick),
    .count_next (cd_next),
    .terminal   (cd_terminal)
  );

  frame_timer #(.WIDTH(FCNT_W), .LIMIT(HIT_FRAMES)) u_hit_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (cur_state != ST_HIT),
    .enable     (1'b1),
    .frame_tick (bus.frame_tick),
    .count_next (hit_next),
    .terminal   (hit_terminal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state       <= ST_IDLE;
      start_q         <= 1'b0;
      bus.game_active <= 1'b0;
      bus.game_over   <= 1'b0;
      bus.countdown   <= 2'd0;
      bus.flash       <= 1'b0;
    end else begin
      cur_state       <= next_state;
      start_q         <= bus.start;
      bus.game_active <= game_active_d;
      bus.game_over   <= game_over_d;
      bus.countdown   <= countdown_d;
      bus.flash       <= flash_d;
    end
  end

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      ST_IDLE, ST_OVER: if (start_rise) next_state = ST_COUNTDOWN;
      ST_COUNTDOWN:     if (bus.frame_tick && cd_terminal) next_state = ST_PLAY;
      ST_PLAY:          if (bus.collision) next_state = (lives == 2'd1) ? ST_OVER : ST_HIT;
      ST_HIT:           if (bus.frame_tick && hit_terminal) next_state = ST_COUNTDOWN;
      default:          next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    game_active_d = (next_state == ST_PLAY);
    game_over_d   = (next_state == ST_OVER);
    countdown_d   = (next_state == ST_COUNTDOWN) ? countdown_digit(cd_next) : 2'd0;
    flash_d       = (next_state == ST_HIT) && ((hit_next & 8'h08) != '0);
  end

  // Subtraction widened by one bit so a borrow shows up as underflow
  assign score_inc  = (score == 16'hFFFF) ? score : score + 16'd1;
  assign level_up   = (score_inc != 16'd0) && ((score_inc % LEVEL_DIV) == 16'd0);
  assign speed_diff = {1'b0, speed} - {1'b0, SPEED_STEP};
  assign speed_dec  = (speed_diff[20] || speed_diff[19:0] < SPEED_MIN) ? SPEED_MIN
                                                                       : speed_diff[19:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score <= 16'd0;
      lives <= LIVES_LOAD;
      speed <= SPEED_INIT;
    end else if (load_game) begin
      score <= 16'd0;
      lives <= LIVES_LOAD;
      speed <= SPEED_INIT;
    end else if (cur_state == ST_PLAY) begin
      if (bus.collision) begin
        lives <= lives - 2'd1;
      end else if (bus.traffic_passed) begin
        score <= score_inc;
        if (level_up)
          speed <= speed_dec;
      end
    end
  end

  assign bus.state = cur_state;
  assign bus.score = score;
  assign bus.lives = lives;
  assign bus.speed = speed;

endmodule

`default_nettype wire

// File: tb/tb_game_sequencer.sv
// ---------------------------------------------------------------------------
// tb_game_sequencer : scoreboard bench driving game_sequencer through a game
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_game_sequencer;

  localparam logic [19:0] SP_INIT = 20'h1FFFF;
  localparam logic [19:0] SP_STEP = 20'h02000;
  localparam logic [19:0] SP_MIN  = 20'h05000;
  localparam logic [2:0]  S_IDLE = 3'd0, S_CD = 3'd1, S_PLAY = 3'd2, S_HIT = 3'd3, S_OVER = 3'd4;

  typedef struct packed {
    logic [2:0]  st;
    logic        ga;
    logic        go;
    logic [19:0] spd;
    logic [15:0] sc;
    logic [1:0]  lv;
    logic [1:0]  cd;
    logic        fl;
  } snap_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  game_sequencer_if bus ();

  game_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model of the game flow
  logic [2:0]  m_state;
  int          m_fcnt;
  int          m_score;
  logic [19:0] m_speed;
  int          m_lives;
  logic        m_sq;
  snap_t       exp_q[$];

  task automatic model_reset();
    m_state = S_IDLE; m_fcnt = 0; m_score = 0; m_speed = SP_INIT; m_lives = 3; m_sq = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic t, input logic c, input logic p);
    logic rise;
    rise = s & ~m_sq;
    m_sq = s;
    case (m_state)
      S_IDLE, S_OVER:
        if (rise) begin
          m_score = 0; m_lives = 3; m_speed = SP_INIT; m_fcnt = 0; m_state = S_CD;
        end
      S_CD:
        if (t) begin
          if (m_fcnt == 179) begin m_fcnt = 0; m_state = S_PLAY; end
          else m_fcnt++;
        end
      S_PLAY:
        if (c) begin
          m_state = (m_lives == 1) ? S_OVER : S_HIT;
          m_lives--;
          m_fcnt = 0;
        end else if (p) begin
          if (m_score < 65535) m_score++;
          if (m_score % 10 == 0) begin
            if (m_speed < SP_MIN + SP_STEP) m_speed = SP_MIN;
            else m_speed = m_speed - SP_STEP;
          end
        end
      S_HIT:
        if (t) begin
          if (m_fcnt == 89) begin m_fcnt = 0; m_state = S_CD; end
          else m_fcnt++;
        end
      default: m_state = S_IDLE;
    endcase
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.st  = m_state;
    s.ga  = (m_state == S_PLAY);
    s.go  = (m_state == S_OVER);
    s.spd = m_speed;
    s.sc  = 16'(m_score);
    s.lv  = 2'(m_lives);
    s.cd  = (m_state != S_CD) ? 2'd0 : (m_fcnt < 60) ? 2'd3 : (m_fcnt < 120) ? 2'd2 : 2'd1;
    s.fl  = (m_state == S_HIT) && ((m_fcnt / 8) % 2 == 1);
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.st  = bus.state;
    s.ga  = bus.game_active;
    s.go  = bus.game_over;
    s.spd = bus.speed;
    s.sc  = bus.score;
    s.lv  = bus.lives;
    s.cd  = bus.countdown;
    s.fl  = bus.flash;
    return s;
  endfunction

  // One clock of stimulus; the expected snapshot is queued before the edge
  task automatic drive(input logic s, input logic t, input logic c, input logic p);
    bus.start = s; bus.frame_tick = t; bus.collision = c; bus.traffic_passed = p;
    model_step(s, t, c, p);
    exp_q.push_back(model_snap());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    snap_t obs, exp;
    rst = 1'b1;
    bus.start = 1'b0; bus.frame_tick = 1'b0; bus.collision = 1'b0; bus.traffic_passed = 1'b0;
    model_reset();
    exp_q.push_back(model_snap());
    repeat (3) @(posedge clk);
    #1;
    obs = dut_snap(); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin
      failures++; $display("FAIL reset got=%h exp=%h", obs, exp);
    end
    rst = 1'b0;
  endtask

  task automatic test_countdown();
    snap_t obs, exp;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    obs = dut_snap(); exp = exp_q.pop_front(); checks++;
    if (obs !== exp || bus.countdown !== 2'd3) begin
      failures++; $display("FAIL start_to_countdown got=%h exp=%h", obs, exp);
    end
    for (int i = 1; i <= 180; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      obs = dut_snap(); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin
        failures++; $display("FAIL countdown tick=%0d got=%h exp=%h", i, obs, exp);
      end
    end
    checks++;
    if (bus.state !== S_PLAY || bus.game_active !== 1'b1 || bus.lives !== 2'd3 || bus.speed !== SP_INIT) begin
      failures++; $display("FAIL enter_play state=%0d active=%b lives=%0d speed=%h exp 2/1/3/%h",
                           bus.state, bus.game_active, bus.lives, bus.speed, SP_INIT);
    end
  endtask

  task automatic test_score_speed();
    snap_t obs, exp;
    for (int i = 1; i <= 150; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      obs = dut_snap(); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin
        failures++; $display("FAIL score pulse=%0d got=%h exp=%h", i, obs, exp);
      end
      if (i == 10 || i == 60 || i == 150) begin
        checks++;
        if (bus.score !== 16'(i) ||
            bus.speed !== ((i == 10) ? 20'h1DFFF : (i == 60) ? 20'h13FFF : 20'h05000)) begin
          failures++; $display("FAIL level_speed pulses=%0d score=%0d speed=%h", i, bus.score, bus.speed);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    snap_t obs, exp;
    for (int i = 0; i < 4; i++) begin
      drive((i % 2) == 0, 1'b0, 1'b0, 1'b0);
      obs = dut_snap(); exp = exp_q.pop_front(); checks++;
      if (obs !== exp || bus.state !== S_PLAY) begin
        failures++; $display("FAIL start_in_play cyc=%0d got=%h exp=%h", i, obs, exp);
      end
    end
  endtask

  task automatic test_collision_hit();
    snap_t obs, exp;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      obs = dut_snap(); exp = exp_q.pop_front(); checks++;
      if (obs !== exp || bus.game_active !== 1'b0 || bus.lives !== 2'd2 || bus.score !== 16'd150) begin
        failures++; $display("FAIL collision_hit cyc=%0d got=%h exp=%h", i, obs, exp);
      end
    end
    for (int i = 1; i <= 270; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      obs = dut_snap(); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin
        failures++; $display("FAIL hit_recover tick=%0d got=%h exp=%h", i, obs, exp);
      end
    end
  endtask

  task automatic test_game_over();
    snap_t obs, exp;
    // start stays high from here so OVER is entered with the button already held
    for (int life = 0; life < 2; life++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      obs = dut_snap(); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin
        failures++; $display("FAIL collision_n=%0d got=%h exp=%h", life, obs, exp);
      end
      if (life == 0) begin
        for (int i = 1; i <= 270; i++) begin
          drive(1'b1, 1'b1, 1'b0, 1'b0);
          obs = dut_snap(); exp = exp_q.pop_front(); checks++;
          if (obs !== exp) begin
            failures++; $display("FAIL last_life tick=%0d got=%h exp=%h", i, obs, exp);
          end
        end
      end
    end
    checks++;
    if (bus.state !== S_OVER || bus.game_over !== 1'b1 || bus.lives !== 2'd0) begin
      failures++; $display("FAIL game_over state=%0d over=%b lives=%0d exp 4/1/0",
                           bus.state, bus.game_over, bus.lives);
    end
    for (int i = 0; i < 8; i++) begin
      drive(i < 5, 1'b1, 1'b0, 1'b0);
      obs = dut_snap(); exp = exp_q.pop_front(); checks++;
      if (obs !== exp || bus.state !== S_OVER) begin
        failures++; $display("FAIL held_start cyc=%0d got=%h exp=%h", i, obs, exp);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    obs = dut_snap(); exp = exp_q.pop_front(); checks++;
    if (obs !== exp || bus.state !== S_CD || bus.score !== 16'd0 || bus.lives !== 2'd3 || bus.speed !== SP_INIT) begin
      failures++; $display("FAIL restart got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_reset_mid_hit();
    snap_t obs, exp;
    for (int i = 1; i <= 180; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 37; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 20; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    while (exp_q.size() > 1) void'(exp_q.pop_front());
    obs = dut_snap(); exp = exp_q.pop_front(); checks++;
    if (obs !== exp || bus.state !== S_HIT || bus.score !== 16'd37) begin
      failures++; $display("FAIL pre_reset got=%h exp=%h", obs, exp);
    end
    #2;
    rst = 1'b1;
    model_reset();
    exp_q.push_back(model_snap());
    #1;
    obs = dut_snap(); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", obs, exp);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    obs = dut_snap(); exp = exp_q.pop_front(); checks++;
    if (obs !== exp || bus.state !== S_IDLE) begin
      failures++; $display("FAIL after_reset got=%h exp=%h", obs, exp);
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_score_speed();
    test_start_ignored();
    test_collision_hit();
    test_game_over();
    test_reset_mid_hit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
